// File: rtl/gemm_pkg.sv
// Shared GEMM constants, the ofmap drain FSM encoding and a row byte-sum helper.
package gemm_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int PE_SIZE         = 14;
    localparam int MEM2_DATA_WIDTH = DATA_WIDTH * PE_SIZE;
    localparam int MEM2_DEPTH      = 896;
    localparam int MEM2_ADDR_WIDTH = 10;

    // skid entry = row data plus its last flag in the MSB
    localparam int DRAIN_ENTRY_W   = MEM2_DATA_WIDTH + 1;

    localparam logic [MEM2_ADDR_WIDTH-1:0] MEM2_LAST_ADDR = MEM2_ADDR_WIDTH'(MEM2_DEPTH - 1);

    typedef logic [MEM2_DATA_WIDTH-1:0] mem2_row_t;

    typedef enum logic [1:0] {
        DRAIN_IDLE  = 2'd0,
        DRAIN_RUN   = 2'd1,
        DRAIN_FLUSH = 2'd2,
        DRAIN_DONE  = 2'd3
    } drain_state_e;

    // unsigned sum of all bytes of one row
    function automatic logic [31:0] row_byte_sum(input mem2_row_t row);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < PE_SIZE; k++) begin
            s = s + 32'(row[k*DATA_WIDTH +: DATA_WIDTH]);
        end
        return s;
    endfunction

endpackage

// File: rtl/drain_skid_fifo.sv
// Two-entry FIFO that absorbs the BRAM read latency and stream backpressure.
// Head entry is never overwritten while it is waiting to be popped.
module drain_skid_fifo
    import gemm_pkg::*;
#(
    parameter int W = DRAIN_ENTRY_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]   occ_q, occ_d;
    logic         do_push, do_pop;

    // pointer/occupancy update; push into a full FIFO only when a pop frees a slot
    always_comb begin
        do_pop   = pop_i && (occ_q != 2'd0);
        do_push  = push_i && ((occ_q != 2'd2) || do_pop);
        ent0_d   = ent0_q;
        ent1_d   = ent1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            if (wr_ptr_q) ent1_d = push_data_i;
            else          ent0_d = push_data_i;
            wr_ptr_d = ~wr_ptr_q;
        end
        if (do_pop) rd_ptr_d = ~rd_ptr_q;
        occ_d = occ_q + 2'(do_push) - 2'(do_pop);
    end

    // storage and pointers, cleared on reset so the stream reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q   <= '0;
            ent1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head_o  = rd_ptr_q ? ent1_q : ent0_q;
    assign empty_o = (occ_q == 2'd0);
    assign occ_o   = occ_q;

endmodule

// File: rtl/ofmap_drain.sv
// ofmap_drain: sweeps mem2 port 1 from row 0 to the last row after GEMM finishes
// and streams every row on a valid/ready interface.
// Optional feature macro OFMAP_DRAIN_CHECKSUM_EN: byte checksum of sent beats on checksum_o.
module ofmap_drain
    import gemm_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       mem2_ce1_o,
    output logic                       mem2_we1_o,
    output logic [MEM2_ADDR_WIDTH-1:0] mem2_addr1_o,
    input  logic [MEM2_DATA_WIDTH-1:0] mem2_q1_i,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [MEM2_DATA_WIDTH-1:0] m_data_o,
    output logic                       m_last_o,
    output logic [31:0]                checksum_o
);

    drain_state_e               state_q, state_d;
    logic [MEM2_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [MEM2_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                       inflight_q, inflight_d;
    logic                       start_acc, pop, issue;
    logic [1:0]                 occ;
    logic                       fifo_empty;
    logic [2:0]                 slots;
    logic [DRAIN_ENTRY_W-1:0]   head;

    assign start_acc = (state_q == DRAIN_IDLE) && start_i;
    assign pop       = m_valid_o && m_ready_i;
    // entries still claimed after this edge; a read is only issued into a free slot
    assign slots     = 3'(occ) + 3'(inflight_q) - 3'(pop);
    assign issue     = (state_q == DRAIN_RUN) && (slots < 3'd2);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= DRAIN_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            DRAIN_IDLE:  if (start_i) state_d = DRAIN_RUN;
            DRAIN_RUN:   if (issue && (rd_addr_q == MEM2_LAST_ADDR)) state_d = DRAIN_FLUSH;
            DRAIN_FLUSH: if (fifo_empty && !inflight_q) state_d = DRAIN_DONE;
            default:     state_d = DRAIN_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_o = (state_q == DRAIN_RUN) || (state_q == DRAIN_FLUSH);
        done_o = (state_q == DRAIN_DONE);
    end

    // read address sweep; stops on the last row so it never wraps
    always_comb begin
        rd_addr_d  = rd_addr_q;
        addr_d     = addr_q;
        inflight_d = issue;
        if (start_acc) begin
            rd_addr_d = '0;
        end else if (issue) begin
            addr_d = rd_addr_q;
            if (rd_addr_q != MEM2_LAST_ADDR) rd_addr_d = rd_addr_q + MEM2_ADDR_WIDTH'(1);
        end
    end

    // registered BRAM port controls; reset also drops any read still in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q  <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            rd_addr_q  <= rd_addr_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
        end
    end

    // ce is high exactly while a read is in flight; its data returns next cycle
    assign mem2_ce1_o   = inflight_q;
    assign mem2_we1_o   = 1'b0;
    assign mem2_addr1_o = addr_q;

    drain_skid_fifo #(.W(DRAIN_ENTRY_W)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i ({addr_q == MEM2_LAST_ADDR, mem2_q1_i}),
        .pop_i       (pop),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .occ_o       (occ)
    );

    assign m_valid_o = !fifo_empty;
    assign m_last_o  = head[MEM2_DATA_WIDTH];
    assign m_data_o  = head[MEM2_DATA_WIDTH-1:0];

`ifdef OFMAP_DRAIN_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    // running byte sum of handshaked beats, restarted on each accepted start
    always_comb begin
        checksum_d = checksum_q;
        if (start_acc)  checksum_d = '0;
        else if (pop)   checksum_d = checksum_q + row_byte_sum(m_data_o);
    end

    // checksum register
    always_ff @(posedge clk) begin
        if (rst) checksum_q <= '0;
        else     checksum_q <= checksum_d;
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_ofmap_drain.sv
// Directed bench for ofmap_drain: BRAM model, handshake scoreboard, stall/reset/restart cases.
module tb_ofmap_drain;
    import gemm_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start_i;
    logic                       busy_o, done_o;
    logic                       mem2_ce1_o, mem2_we1_o;
    logic [MEM2_ADDR_WIDTH-1:0] mem2_addr1_o;
    logic [MEM2_DATA_WIDTH-1:0] mem2_q1_i;
    logic                       m_valid_o, m_ready_i, m_last_o;
    logic [MEM2_DATA_WIDTH-1:0] m_data_o;
    logic [31:0]                checksum_o;

    ofmap_drain dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .mem2_ce1_o   (mem2_ce1_o),
        .mem2_we1_o   (mem2_we1_o),
        .mem2_addr1_o (mem2_addr1_o),
        .mem2_q1_i    (mem2_q1_i),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_data_o     (m_data_o),
        .m_last_o     (m_last_o),
        .checksum_o   (checksum_o)
    );

    always #5 clk = ~clk;

    logic [MEM2_DATA_WIDTH-1:0] mem [0:MEM2_DEPTH-1];

    // BRAM model: data for the read presented on ce/addr
    assign mem2_q1_i = (mem2_ce1_o && (int'(mem2_addr1_o) < MEM2_DEPTH)) ? mem[mem2_addr1_o] : '0;

    int checks = 0;
    int errors = 0;

    int beats, reads, dones, beat_err, addr_err, we_err, last_cnt, hold_err;
    int stall_reads, stall_vld_err, first_ce, first_vld, first_beat, last_beat, done_c;
    logic [31:0] cks_at_done, exp_cks;
    logic        hold_prev, prev_last;
    logic [MEM2_DATA_WIDTH-1:0] prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MEM2_DATA_WIDTH-1:0] pat_row(input int i);
        logic [MEM2_DATA_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < PE_SIZE; k++) r[(PE_SIZE-1-k)*8 +: 8] = 8'((i + k) % 256);
        return r;
    endfunction

    function automatic logic [31:0] bytes_sum(input logic [MEM2_DATA_WIDTH-1:0] r);
        logic [31:0] s;
        s = 0;
        for (int k = 0; k < MEM2_DATA_WIDTH / 8; k++) s = s + {24'd0, r[k*8 +: 8]};
        return s;
    endfunction

    // mode 0: ready high, 1: 1010.., 2: ~30% random stalls
    task automatic run_drain(input int mode, input int stall_cycles, input int mid_start_at,
                             input int rst_at, output bit aborted);
        logic rdy;
        beats = 0; reads = 0; dones = 0; beat_err = 0; addr_err = 0; we_err = 0;
        last_cnt = 0; hold_err = 0; stall_reads = 0; stall_vld_err = 0;
        first_ce = -1; first_vld = -1; first_beat = -1; last_beat = -1; done_c = -1;
        exp_cks = 0; cks_at_done = 32'hdead_beef; hold_prev = 1'b0; aborted = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        m_ready_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (mem2_ce1_o) begin
                if (first_ce < 0) first_ce = c;
                if (int'(mem2_addr1_o) != reads) addr_err++;
                reads++;
                if (c < stall_cycles) stall_reads++;
            end
            if (mem2_we1_o) we_err++;
            if (m_valid_o && first_vld < 0) first_vld = c;
            if (c >= 2 && c < stall_cycles && !m_valid_o) stall_vld_err++;
            if (hold_prev && (!m_valid_o || m_data_o !== prev_data || m_last_o !== prev_last)) hold_err++;
            if (rst_at >= 0 && beats == rst_at) begin
                m_ready_i = 1'b1;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 2 == 0);
                default: rdy = ($urandom_range(0, 99) >= 30);
            endcase
            if (c < stall_cycles) rdy = 1'b0;
            if (m_valid_o && rdy) begin
                if (beats >= MEM2_DEPTH) beat_err++;
                else begin
                    if (m_data_o !== mem[beats] || m_last_o !== (beats == MEM2_DEPTH - 1)) beat_err++;
                    exp_cks = exp_cks + bytes_sum(mem[beats]);
                end
                if (m_last_o) last_cnt++;
                if (first_beat < 0) first_beat = c;
                last_beat = c;
                beats++;
            end
            hold_prev = m_valid_o && !rdy;
            prev_data = m_data_o;
            prev_last = m_last_o;
            m_ready_i = rdy;
            start_i = (c == mid_start_at);
            tick();
            start_i = 1'b0;
            if (done_o) begin
                dones++;
                cks_at_done = checksum_o;
                if (done_c < 0) done_c = c;
            end
            if (done_c >= 0 && c >= done_c + 5) break;
        end
        m_ready_i = 1'b0;
    endtask

    task automatic check_run(input string tag, input logic [31:0] exp_checksum);
        check({tag, ".beats"},    beats,    MEM2_DEPTH);
        check({tag, ".reads"},    reads,    MEM2_DEPTH);
        check({tag, ".addr_seq"}, addr_err, 0);
        check({tag, ".data"},     beat_err, 0);
        check({tag, ".last"},     last_cnt, 1);
        check({tag, ".done"},     dones,    1);
        check({tag, ".we"},       we_err,   0);
        check({tag, ".hold"},     hold_err, 0);
        check({tag, ".busy_end"}, busy_o,   1'b0);
        check({tag, ".cks_done"}, cks_at_done, exp_checksum);
        check({tag, ".cks_hold"}, checksum_o,  exp_checksum);
    endtask

    function automatic logic [31:0] want_cks(input logic [31:0] model);
`ifdef OFMAP_DRAIN_CHECKSUM_EN
        return model;
`else
        return (model == 32'hffff_ffff) ? 32'd1 : 32'd0;
`endif
    endfunction

    initial begin
        bit ab;
        rst = 1'b1;
        start_i = 1'b0;
        m_ready_i = 1'b0;
        for (int i = 0; i < MEM2_DEPTH; i++) mem[i] = pat_row(i);
        repeat (3) tick();

        // reset state
        check("rst.busy",  busy_o,       1'b0);
        check("rst.done",  done_o,       1'b0);
        check("rst.ce",    mem2_ce1_o,   1'b0);
        check("rst.we",    mem2_we1_o,   1'b0);
        check("rst.addr",  mem2_addr1_o, 0);
        check("rst.valid", m_valid_o,    1'b0);
        check("rst.data",  |m_data_o,    1'b0);
        check("rst.last",  m_last_o,     1'b0);
        check("rst.cks",   checksum_o,   0);
        rst = 1'b0;
        tick();

        // full-rate sweep
        run_drain(0, 0, -1, -1, ab);
        check("A.first_ce",  first_ce,  1);
        check("A.first_vld", first_vld, 2);
        check("A.span",      last_beat - first_beat + 1, MEM2_DEPTH);
        check_run("A", want_cks(exp_cks));

        // ready 1010..
        run_drain(1, 0, -1, -1, ab);
        check_run("B", want_cks(exp_cks));

        // random stalls
        run_drain(2, 0, -1, -1, ab);
        check_run("C", want_cks(exp_cks));

        // ready held low for 50 cycles after start
        run_drain(0, 50, -1, -1, ab);
        check("D.stall_reads", stall_reads,   2);
        check("D.stall_valid", stall_vld_err, 0);
        check_run("D", want_cks(exp_cks));

        // second start pulse mid-run is ignored
        run_drain(0, 0, 300, -1, ab);
        check_run("E", want_cks(exp_cks));

        // reset at beat 400
        run_drain(0, 0, -1, 400, ab);
        check("F.aborted", ab,           1'b1);
        check("F.beats",   beats,        400);
        check("F.valid",   m_valid_o,    1'b0);
        check("F.busy",    busy_o,       1'b0);
        check("F.done",    done_o,       1'b0);
        check("F.ce",      mem2_ce1_o,   1'b0);
        check("F.data",    |m_data_o,    1'b0);
        check("F.addr",    mem2_addr1_o, 0);
        tick();
        check("F.done2",   done_o,       1'b0);
        run_drain(0, 0, -1, -1, ab);
        check_run("G", want_cks(exp_cks));

        // all-ones bytes: 896 rows * 14 bytes
        for (int i = 0; i < MEM2_DEPTH; i++) mem[i] = {PE_SIZE{8'h01}};
        run_drain(0, 0, -1, -1, ab);
`ifdef OFMAP_DRAIN_CHECKSUM_EN
        check_run("H", 32'd12544);
`else
        check_run("H", 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
